// File: rtl/debug_port.sv
`default_nettype none
// ============================================================================
// Module   : debug_port
// Purpose  : Host command port that turns status/read/write requests into
//            debug bus cycles (DARGRD/DARGWR) while the CPU is halted, with
//            timeout and stop-loss abort handling.
// Revision : 1.0 - initial release
// ============================================================================
module debug_port #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HOST_CMD_VALID,
  output logic        HOST_CMD_READY,
  input  logic [1:0]  HOST_CMD,
  input  logic [15:0] HOST_ADDR,
  input  logic [15:0] HOST_WDATA,
  output logic        HOST_RSP_VALID,
  input  logic        HOST_RSP_READY,
  output logic [15:0] HOST_RSP_DATA,
  output logic        HOST_RSP_ERR,
  input  logic        STOPPED,
  output logic        DEBUG_REQ,
  output logic        DEBUG_OP,
  output logic [15:0] DEBUG_ADDR,
  output logic [15:0] DEBUG_DOUT,
  input  logic        DEBUG_RD,
  input  logic        DEBUG_WR,
  input  logic [15:0] DEBUG_DIN
);

  localparam logic [1:0]  CMD_STATUS = 2'b00;
  localparam logic [1:0]  CMD_WRITE  = 2'b10;
  localparam logic [1:0]  CMD_RDNEXT = 2'b11;
  localparam logic [15:0] CNT_LAST   = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        debug_req_q, debug_req_d;
  logic        debug_op_q, debug_op_d;
  // The debug address register doubles as the "last address" used by cmd 11.
  logic [15:0] debug_addr_q, debug_addr_d;
  logic [15:0] debug_dout_q, debug_dout_d;
  logic [15:0] cnt_q, cnt_d;

  logic [15:0] cmd_addr;
  logic        strobe_match;

  // Next-state logic: command acceptance, bus completion and abort handling.
  always_comb begin
    state_d      = state_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    debug_req_d  = debug_req_q;
    debug_op_d   = debug_op_q;
    debug_addr_d = debug_addr_q;
    debug_dout_d = debug_dout_q;
    cnt_d        = cnt_q;

    cmd_addr     = (HOST_CMD == CMD_RDNEXT) ? (debug_addr_q + 16'd2) : HOST_ADDR;
    // Only the strobe belonging to the issued operation completes it.
    strobe_match = (DEBUG_RD & ~debug_op_q) | (DEBUG_WR & debug_op_q);

    case (state_q)
      IDLE: begin
        if (HOST_CMD_VALID) begin
          if (HOST_CMD == CMD_STATUS) begin
            rsp_data_d = {15'b0, STOPPED};
            rsp_err_d  = 1'b0;
            state_d    = RESP;
          end else if (!STOPPED) begin
            rsp_data_d = 16'h0000;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end else begin
            debug_addr_d = cmd_addr;
            debug_op_d   = (HOST_CMD == CMD_WRITE);
            if (HOST_CMD == CMD_WRITE) begin
              debug_dout_d = HOST_WDATA;
            end
            debug_req_d = 1'b1;
            cnt_d       = 16'd0;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        // Precedence: matching strobe, then timeout, then loss of STOPPED.
        if (strobe_match) begin
          rsp_data_d  = debug_op_q ? debug_dout_q : DEBUG_DIN;
          rsp_err_d   = 1'b0;
          debug_req_d = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d  = 16'hFFFF;
          rsp_err_d   = 1'b1;
          debug_req_d = 1'b0;
          state_d     = RESP;
        end else if (!STOPPED) begin
          rsp_data_d  = 16'h0000;
          rsp_err_d   = 1'b1;
          debug_req_d = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (HOST_RSP_READY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        debug_req_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      rsp_data_q   <= 16'h0000;
      rsp_err_q    <= 1'b0;
      debug_req_q  <= 1'b0;
      debug_op_q   <= 1'b0;
      debug_addr_q <= 16'h0000;
      debug_dout_q <= 16'h0000;
      cnt_q        <= 16'h0000;
    end else begin
      state_q      <= state_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      debug_req_q  <= debug_req_d;
      debug_op_q   <= debug_op_d;
      debug_addr_q <= debug_addr_d;
      debug_dout_q <= debug_dout_d;
      cnt_q        <= cnt_d;
    end
  end

  assign HOST_CMD_READY = (state_q == IDLE) & ~RESET;
  assign HOST_RSP_VALID = (state_q == RESP);
  assign HOST_RSP_DATA  = rsp_data_q;
  assign HOST_RSP_ERR   = rsp_err_q;
  assign DEBUG_REQ      = debug_req_q;
  assign DEBUG_OP       = debug_op_q;
  assign DEBUG_ADDR     = debug_addr_q;
  assign DEBUG_DOUT     = debug_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_port
// Purpose  : Scoreboard bench for debug_port; directed cases plus randomized
//            commands checked against a behavioural model of the port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_port;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        HOST_CMD_VALID = 1'b0;
  logic        HOST_CMD_READY;
  logic [1:0]  HOST_CMD = 2'b00;
  logic [15:0] HOST_ADDR = 16'h0;
  logic [15:0] HOST_WDATA = 16'h0;
  logic        HOST_RSP_VALID;
  logic        HOST_RSP_READY = 1'b0;
  logic [15:0] HOST_RSP_DATA;
  logic        HOST_RSP_ERR;
  logic        STOPPED = 1'b1;
  logic        DEBUG_REQ;
  logic        DEBUG_OP;
  logic [15:0] DEBUG_ADDR;
  logic [15:0] DEBUG_DOUT;
  logic        DEBUG_RD = 1'b0;
  logic        DEBUG_WR = 1'b0;
  logic [15:0] DEBUG_DIN = 16'h0;

  debug_port #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .HOST_CMD_VALID(HOST_CMD_VALID), .HOST_CMD_READY(HOST_CMD_READY),
    .HOST_CMD(HOST_CMD), .HOST_ADDR(HOST_ADDR), .HOST_WDATA(HOST_WDATA),
    .HOST_RSP_VALID(HOST_RSP_VALID), .HOST_RSP_READY(HOST_RSP_READY),
    .HOST_RSP_DATA(HOST_RSP_DATA), .HOST_RSP_ERR(HOST_RSP_ERR),
    .STOPPED(STOPPED), .DEBUG_REQ(DEBUG_REQ), .DEBUG_OP(DEBUG_OP),
    .DEBUG_ADDR(DEBUG_ADDR), .DEBUG_DOUT(DEBUG_DOUT),
    .DEBUG_RD(DEBUG_RD), .DEBUG_WR(DEBUG_WR), .DEBUG_DIN(DEBUG_DIN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  // Reference model state: last debug address and last write data.
  logic [15:0] m_addr = 16'h0;
  logic [15:0] m_dout = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected response at each handshake and checks hold stability.
  initial begin : monitor
    logic [15:0] cap_d;
    logic        cap_e;
    logic        have;
    logic        unstable;
    rsp_t        e;
    have = 1'b0;
    unstable = 1'b0;
    forever begin
      @(negedge CLK);
      #1;
      if (RESET) begin
        have = 1'b0;
      end else if (HOST_RSP_VALID) begin
        if (!have) begin
          cap_d = HOST_RSP_DATA;
          cap_e = HOST_RSP_ERR;
          have = 1'b1;
          unstable = 1'b0;
        end else if (HOST_RSP_DATA !== cap_d || HOST_RSP_ERR !== cap_e) begin
          unstable = 1'b1;
        end
        if (HOST_RSP_READY) begin
          chk("rsp_hold_stable", {31'b0, unstable}, 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got data %h err %b, expected none", HOST_RSP_DATA, HOST_RSP_ERR);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_data", {16'b0, HOST_RSP_DATA}, {16'b0, e.data});
            chk("rsp_err", {31'b0, HOST_RSP_ERR}, {31'b0, e.err});
          end
          have = 1'b0;
        end
      end
    end
  end

  // Issue one command. d: BUSY cycle of the matching strobe (-1 none);
  // k: BUSY cycle where STOPPED drops (-1 never); stray: drive the opposite
  // strobe every BUSY cycle; wait_c: cycles the host holds off the response.
  task automatic send(input logic [1:0] cmd, input logic [15:0] addr, input logic [15:0] wdata,
                      input logic [15:0] din, input logic stp, input int d, input int k,
                      input bit stray, input int wait_c);
    rsp_t e;
    bit   busy;
    bit   op;
    int   last;
    busy = 1'b0;
    op = (cmd == 2'b10);
    last = 0;
    if (cmd == 2'b00) begin
      e.data = {15'b0, stp};
      e.err = 1'b0;
    end else if (!stp) begin
      e.data = 16'h0000;
      e.err = 1'b1;
    end else begin
      busy = 1'b1;
      m_addr = (cmd == 2'b11) ? m_addr + 16'd2 : addr;
      if (op) m_dout = wdata;
      // The earliest terminating event wins; ties follow match > timeout > stop.
      last = TO - 1;
      e.data = 16'hFFFF;
      e.err = 1'b1;
      if (k >= 0 && k < last) begin
        last = k;
        e.data = 16'h0000;
        e.err = 1'b1;
      end
      if (d >= 0 && d <= last) begin
        last = d;
        e.data = op ? m_dout : din;
        e.err = 1'b0;
      end
    end

    @(negedge CLK);
    chk("cmd_ready_idle", {31'b0, HOST_CMD_READY}, 32'd1);
    STOPPED = stp;
    HOST_CMD = cmd;
    HOST_ADDR = addr;
    HOST_WDATA = wdata;
    HOST_CMD_VALID = 1'b1;
    exp_q.push_back(e);
    @(posedge CLK);
    #1 HOST_CMD_VALID = 1'b0;

    if (busy) begin
      for (int i = 0; i <= last; i++) begin
        @(negedge CLK);
        chk("debug_req_busy", {31'b0, DEBUG_REQ}, 32'd1);
        chk("rsp_valid_busy", {31'b0, HOST_RSP_VALID}, 32'd0);
        chk("debug_addr", {16'b0, DEBUG_ADDR}, {16'b0, m_addr});
        chk("debug_op", {31'b0, DEBUG_OP}, {31'b0, op});
        if (op) chk("debug_dout", {16'b0, DEBUG_DOUT}, {16'b0, m_dout});
        DEBUG_RD = (!op && i == d) || (op && stray);
        DEBUG_WR = (op && i == d) || (!op && stray);
        DEBUG_DIN = (i == d) ? din : 16'($urandom);
        STOPPED = !(k >= 0 && i >= k);
      end
    end
    @(negedge CLK);
    DEBUG_RD = 1'b0;
    DEBUG_WR = 1'b0;
    chk("debug_req_done", {31'b0, DEBUG_REQ}, 32'd0);
    chk("rsp_valid", {31'b0, HOST_RSP_VALID}, 32'd1);
    chk("cmd_ready_resp", {31'b0, HOST_CMD_READY}, 32'd0);
    repeat (wait_c) @(negedge CLK);
    HOST_RSP_READY = 1'b1;
    @(posedge CLK);
    #1 HOST_RSP_READY = 1'b0;
  endtask

  // Read command aborted by reset while BUSY; no response may appear.
  task automatic reset_mid_busy();
    @(negedge CLK);
    STOPPED = 1'b1;
    HOST_CMD = 2'b01;
    HOST_ADDR = 16'hABCD;
    HOST_CMD_VALID = 1'b1;
    @(posedge CLK);
    #1 HOST_CMD_VALID = 1'b0;
    @(negedge CLK);
    chk("rst_req_before", {31'b0, DEBUG_REQ}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("rst_req_async", {31'b0, DEBUG_REQ}, 32'd0);
    chk("rst_ready_low", {31'b0, HOST_CMD_READY}, 32'd0);
    chk("rst_addr_clear", {16'b0, DEBUG_ADDR}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    m_addr = 16'h0;
    m_dout = 16'h0;
    @(negedge CLK);
    chk("rst_ready_after", {31'b0, HOST_CMD_READY}, 32'd1);
    chk("rst_no_rsp", {31'b0, HOST_RSP_VALID}, 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (2) @(negedge CLK);
    chk("reset_ready", {31'b0, HOST_CMD_READY}, 32'd0);
    chk("reset_req", {31'b0, DEBUG_REQ}, 32'd0);
    chk("reset_op", {31'b0, DEBUG_OP}, 32'd0);
    chk("reset_valid", {31'b0, HOST_RSP_VALID}, 32'd0);
    chk("reset_err", {31'b0, HOST_RSP_ERR}, 32'd0);
    chk("reset_rdata", {16'b0, HOST_RSP_DATA}, 32'd0);
    chk("reset_addr", {16'b0, DEBUG_ADDR}, 32'd0);
    chk("reset_dout", {16'b0, DEBUG_DOUT}, 32'd0);
    RESET = 1'b0;

    // Directed cases.
    send(2'b01, 16'h5555, 16'h0000, 16'h3333, 1'b1, 1, -1, 1'b0, 0);
    send(2'b10, 16'h1234, 16'h4444, 16'h0000, 1'b1, 3, -1, 1'b1, 1);
    send(2'b01, 16'hFFFE, 16'h0000, 16'h0101, 1'b1, 0, -1, 1'b0, 0);
    send(2'b11, 16'h0000, 16'h0000, 16'h0202, 1'b1, 0, -1, 1'b0, 0);
    send(2'b11, 16'h0000, 16'h0000, 16'h0303, 1'b1, 0, -1, 1'b0, 0);
    send(2'b01, 16'h7777, 16'h0000, 16'h0000, 1'b0, 0, -1, 1'b0, 0);
    send(2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b0, -1, -1, 1'b0, 0);
    send(2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b1, -1, -1, 1'b0, 0);
    send(2'b01, 16'h0040, 16'h0000, 16'h0000, 1'b1, -1, -1, 1'b0, 0);
    send(2'b01, 16'h0040, 16'h0000, 16'h9ABC, 1'b1, 3, -1, 1'b0, 0);
    send(2'b01, 16'h0050, 16'h0000, 16'h0000, 1'b1, -1, 1, 1'b0, 0);
    send(2'b01, 16'h0060, 16'h0000, 16'h0000, 1'b1, -1, 3, 1'b0, 0);
    send(2'b01, 16'h0070, 16'h0000, 16'h5A5A, 1'b1, 2, 2, 1'b0, 0);
    reset_mid_busy();
    send(2'b11, 16'h0000, 16'h0000, 16'hC0DE, 1'b1, 0, -1, 1'b0, 5);

    // Randomized commands.
    for (int n = 0; n < 60; n++) begin
      logic [1:0] c;
      int d;
      int k;
      c = 2'($urandom_range(0, 3));
      d = int'($urandom_range(0, 6)) - 1;
      k = ($urandom_range(0, 9) > 6) ? int'($urandom_range(0, 5)) : -1;
      send(c, 16'($urandom), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 7) != 0), d, k, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debug_port.md
DEBUG_PORT -- requirements
Module: debug_port

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles DEBUG_REQ may stay high without a completing strobe before the access is aborted.
REQ-002 CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 HOST_CMD_VALID  input  1  host command valid.
REQ-005 HOST_CMD_READY  output  1  port can accept a command.
REQ-006 HOST_CMD  input  2  command: 00 status, 01 read, 10 write, 11 read at last address+2.
REQ-007 HOST_ADDR  input  16  word address for commands 01 and 10.
REQ-008 HOST_WDATA  input  16  write data for command 10.
REQ-009 HOST_RSP_VALID  output  1  response valid.
REQ-010 HOST_RSP_READY  input  1  host accepts the response.
REQ-011 HOST_RSP_DATA  output  16  response data.
REQ-012 HOST_RSP_ERR  output  1  response error flag.
REQ-013 STOPPED  input  1  CPU halted; debug bus cycles are permitted only while this is high.
REQ-014 DEBUG_REQ  output  1  request to the sequencer for a debug bus cycle (DARGRD or DARGWR).
REQ-015 DEBUG_OP  output  1  0 = read (DARGRD), 1 = write (DARGWR).
REQ-016 DEBUG_ADDR  output  16  address to busInterface.
REQ-017 DEBUG_DOUT  output  16  write data to busInterface.
REQ-018 DEBUG_RD  input  1  busInterface read strobe; DEBUG_DIN is valid in the same cycle.
REQ-019 DEBUG_WR  input  1  busInterface write strobe; the write has completed.
REQ-020 DEBUG_DIN  input  16  read data from busInterface.

Function
REQ-021 The FSM SHALL have three states, IDLE, BUSY and RESP; HOST_CMD_READY SHALL be 1 in IDLE only, and HOST_RSP_VALID SHALL be 1 in RESP only.
REQ-022 A command SHALL be accepted on a rising edge where HOST_CMD_VALID and HOST_CMD_READY are both 1; cmd, addr and wdata are latched on that edge.
REQ-023 Command 00 SHALL go to RESP with RSP_DATA = {15'b0, STOPPED} and ERR = 0, and SHALL NOT assert DEBUG_REQ.
REQ-024 Command 01/10/11 with STOPPED = 0 at acceptance SHALL go to RESP with RSP_DATA = 0000 and ERR = 1, and SHALL NOT assert DEBUG_REQ.
REQ-025 Command 01/10/11 with STOPPED = 1 SHALL set the registers below and go to BUSY; DEBUG_REQ and DEBUG_OP are registered and valid in the first BUSY cycle.
- DEBUG_ADDR = HOST_ADDR for 01/10; DEBUG_ADDR = addr_reg + 2 (16-bit wrap, FFFE -> 0000) for 11.
- addr_reg = DEBUG_ADDR.
- DEBUG_DOUT = HOST_WDATA for 10; unchanged otherwise.
REQ-026 In BUSY, DEBUG_REQ SHALL stay 1 and a timeout counter SHALL increment every cycle starting from 0.
REQ-027 BUSY read completion: DEBUG_RD = 1 with DEBUG_OP = 0 SHALL capture DEBUG_DIN into RSP_DATA with ERR = 0, clear DEBUG_REQ and go to RESP on the same edge.
REQ-028 BUSY write completion: DEBUG_WR = 1 with DEBUG_OP = 1 SHALL set RSP_DATA = DEBUG_DOUT with ERR = 0, clear DEBUG_REQ and go to RESP.
REQ-029 A strobe that does not match DEBUG_OP SHALL be ignored.
REQ-030 Timeout: when the counter reaches TIMEOUT-1 with no matching strobe, the port SHALL go to RESP with RSP_DATA = FFFF and ERR = 1 and clear DEBUG_REQ.
REQ-031 STOPPED falling in BUSY: the port SHALL go to RESP with RSP_DATA = 0000 and ERR = 1 and clear DEBUG_REQ.
REQ-032 Precedence for simultaneous events in one cycle: matching strobe beats timeout, and timeout beats STOPPED low.
REQ-033 RESP SHALL hold RSP_DATA and ERR stable until HOST_RSP_READY = 1, then return to IDLE on that edge; a new command is accepted no earlier than the following edge.
REQ-034 Latency from command acceptance edge N (command 01, with DEBUG_RD on the first BUSY cycle) SHALL be DEBUG_REQ high after N, response valid after N+1.

Reset
REQ-035 While RESET = 1, the port SHALL asynchronously force the following, and SHALL return HOST_CMD_READY = 1 once RESET is released.
- State IDLE; HOST_CMD_READY = 0 while RESET is asserted.
- HOST_RSP_VALID, HOST_RSP_ERR, DEBUG_REQ, DEBUG_OP = 0.
- HOST_RSP_DATA, DEBUG_ADDR, DEBUG_DOUT, addr_reg, counter = 0000.
REQ-036 RESET during BUSY or RESP SHALL drop DEBUG_REQ immediately and discard the pending response.

Verification
REQ-037 STOPPED = 1; cmd 01 addr 5555; DEBUG_RD with DEBUG_DIN = 3333 on the 2nd BUSY cycle -> DEBUG_ADDR = 5555, DEBUG_OP = 0, response 3333, ERR = 0.
REQ-038 cmd 10 addr 1234 wdata 4444; DEBUG_WR after 3 cycles -> DEBUG_DOUT = 4444, DEBUG_OP = 1, response 4444, ERR = 0; a stray DEBUG_RD before DEBUG_WR is ignored.
REQ-039 cmd 01 addr FFFE, then cmd 11 twice -> DEBUG_ADDR sequence FFFE, 0000, 0002.
REQ-040 STOPPED = 0; cmd 01 -> no DEBUG_REQ, response 0000, ERR = 1; cmd 00 -> response 0000, ERR = 0.
REQ-041 TIMEOUT = 4, no strobe -> DEBUG_REQ high for exactly 4 cycles, response FFFF, ERR = 1; repeat with DEBUG_RD on the final cycle -> data response, ERR = 0.
REQ-042 RESET asserted mid-BUSY -> DEBUG_REQ = 0 without waiting for a clock edge, no response issued, HOST_CMD_READY = 1 after release; HOST_RSP_READY held low in RESP for 5 cycles -> data held stable.
